// File: rtl/clock_pkg.sv
// Shared mode encoding, BCD field limits and the BCD increment helper
// for the digital clock timekeeping block.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_SET_H = 2'd1,
      MODE_SET_M = 2'd2,
      MODE_SET_S = 2'd3
   } mode_e;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] SEC_MAX  = 8'h59;

   // Next BCD value, wrapping to 00 after max; only legal BCD is produced.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping at MAX; wrap flags the rollover increment
// so a caller can chain the next field.
module bcd_wrap_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX     = 8'h59,
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] r_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_val <= RST_VAL;
      else if (load)
         r_val <= load_val;
      else if (inc)
         r_val <= bcd_inc(r_val, MAX);
   end

   assign value = r_val;
   assign wrap  = inc && (r_val == MAX);

endmodule

// File: rtl/clock_time_ctrl.sv
// Clock timekeeping and set-mode controller: chains the h/m/s BCD counters
// in RUN, steps fields from key_inc in SET states, drives blink and div_clr.
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter logic [7:0] RST_HOUR = 8'h12,
   parameter logic [7:0] RST_MIN  = 8'h00,
   parameter logic [7:0] RST_SEC  = 8'h00
) (
   input  logic       clk_27MHz,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] mode,
   output logic [2:0] blank,
   output logic       div_clr
);

   mode_e      r_mode, w_mode_nxt;
   logic       r_blink, w_blink_nxt;
   logic [2:0] r_blank, w_blank_nxt;
   logic       r_div_clr, w_div_clr_nxt;

   logic w_run, w_set_inc;
   logic w_sec_inc, w_min_inc, w_hour_inc;
   logic w_sec_wrap, w_min_wrap, w_hour_wrap;

   // A mode key in the same cycle swallows the increment.
   assign w_run     = (r_mode == MODE_RUN);
   assign w_set_inc = key_inc && !key_mode;

   assign w_sec_inc  = w_run ? tick_1hz   : (w_set_inc && r_mode == MODE_SET_S);
   assign w_min_inc  = w_run ? w_sec_wrap : (w_set_inc && r_mode == MODE_SET_M);
   assign w_hour_inc = w_run ? w_min_wrap : (w_set_inc && r_mode == MODE_SET_H);

   bcd_wrap_counter #(.MAX(SEC_MAX), .RST_VAL(RST_SEC)) u_sec (
      .clk(clk_27MHz), .rst_n(rst_n), .inc(w_sec_inc), .load(1'b0),
      .load_val(8'h00), .value(sec_bcd), .wrap(w_sec_wrap)
   );

   bcd_wrap_counter #(.MAX(MIN_MAX), .RST_VAL(RST_MIN)) u_min (
      .clk(clk_27MHz), .rst_n(rst_n), .inc(w_min_inc), .load(1'b0),
      .load_val(8'h00), .value(min_bcd), .wrap(w_min_wrap)
   );

   bcd_wrap_counter #(.MAX(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
      .clk(clk_27MHz), .rst_n(rst_n), .inc(w_hour_inc), .load(1'b0),
      .load_val(8'h00), .value(hour_bcd), .wrap(w_hour_wrap)
   );

   always_ff @(posedge clk_27MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= MODE_RUN;
         r_blink   <= 1'b0;
         r_blank   <= 3'b000;
         r_div_clr <= 1'b0;
      end else begin
         r_mode    <= w_mode_nxt;
         r_blink   <= w_blink_nxt;
         r_blank   <= w_blank_nxt;
         r_div_clr <= w_div_clr_nxt;
      end
   end

   always_comb begin
      w_mode_nxt    = r_mode;
      w_blink_nxt   = r_blink;
      w_blank_nxt   = 3'b000;
      w_div_clr_nxt = 1'b0;

      if (key_mode) begin
         unique case (r_mode)
            MODE_RUN:   w_mode_nxt = MODE_SET_H;
            MODE_SET_H: w_mode_nxt = MODE_SET_M;
            MODE_SET_M: w_mode_nxt = MODE_SET_S;
            MODE_SET_S: w_mode_nxt = MODE_RUN;
         endcase
      end

      // Entering any SET state restarts the blink phase visibly lit.
      if (key_mode && r_mode != MODE_SET_S)
         w_blink_nxt = 1'b0;
      else if (tick_1hz)
         w_blink_nxt = !r_blink;

      unique case (w_mode_nxt)
         MODE_SET_H: w_blank_nxt = {w_blink_nxt, 2'b00};
         MODE_SET_M: w_blank_nxt = {1'b0, w_blink_nxt, 1'b0};
         MODE_SET_S: w_blank_nxt = {2'b00, w_blink_nxt};
         default:    w_blank_nxt = 3'b000;
      endcase

      w_div_clr_nxt = key_mode && (r_mode == MODE_SET_S);
   end

   assign mode    = r_mode;
   assign blank   = r_blank;
   assign div_clr = r_div_clr;

   // The hour wrap has no consumer; 23:59:59 simply rolls to 00:00:00.
   logic w_unused;
   assign w_unused = w_hour_wrap;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: hand-computed expectations for run,
// set, carry, blink, div_clr and reset behaviour.
module tb_clock_time_ctrl;

   logic       clk_27MHz = 1'b0;
   logic       rst_n     = 1'b0;
   logic       tick_1hz  = 1'b0;
   logic       key_mode  = 1'b0;
   logic       key_inc   = 1'b0;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic [1:0] mode;
   logic [2:0] blank;
   logic       div_clr;

   int n_chk = 0;
   int n_err = 0;
   int dc_cnt = 0;

   clock_time_ctrl dut (
      .clk_27MHz(clk_27MHz), .rst_n(rst_n), .tick_1hz(tick_1hz),
      .key_mode(key_mode), .key_inc(key_inc), .hour_bcd(hour_bcd),
      .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode), .blank(blank),
      .div_clr(div_clr)
   );

   always #5 clk_27MHz = ~clk_27MHz;

   always @(negedge clk_27MHz) if (rst_n && div_clr) dc_cnt++;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock with the given pulses; returns at posedge+1 with inputs low.
   task automatic cyc(input logic t, input logic m, input logic i);
      tick_1hz = t; key_mode = m; key_inc = i;
      @(posedge clk_27MHz); #1;
      tick_1hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".hour"}, hour_bcd, 8'h12);
      chk({tag, ".min"}, min_bcd, 8'h00);
      chk({tag, ".sec"}, sec_bcd, 8'h00);
      chk({tag, ".mode"}, 8'(mode), 8'd0);
      chk({tag, ".blank"}, 8'(blank), 8'd0);
      chk({tag, ".divclr"}, 8'(div_clr), 8'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #23;
      chk_reset("rst");
      rst_n = 1'b1;
      @(posedge clk_27MHz); #1;
      chk_reset("post_rst");

      ticks(5);
      chk("run5.sec", sec_bcd, 8'h05);

      // SET_H: ticks frozen, blink lit after one tick, hour wraps past 23
      cyc(1'b0, 1'b1, 1'b0);
      chk("seth.mode", 8'(mode), 8'd1);
      chk("seth.blank0", 8'(blank), 8'h0);
      ticks(1);
      chk("seth.sec_frozen", sec_bcd, 8'h05);
      chk("seth.blank1", 8'(blank), 8'h4);
      incs(13);
      chk("seth.hour13", hour_bcd, 8'h01);
      chk("seth.min", min_bcd, 8'h00);
      chk("seth.sec", sec_bcd, 8'h05);
      incs(22);
      chk("seth.hour23", hour_bcd, 8'h23);

      // SET_M: blink cleared on entry, toggles per tick
      cyc(1'b0, 1'b1, 1'b0);
      chk("setm.mode", 8'(mode), 8'd2);
      chk("setm.blank0", 8'(blank), 8'h0);
      incs(59);
      chk("setm.min59", min_bcd, 8'h59);
      chk("setm.hour", hour_bcd, 8'h23);
      ticks(1);
      chk("setm.blank_t1", 8'(blank), 8'h2);
      ticks(1);
      chk("setm.blank_t2", 8'(blank), 8'h0);
      chk("setm.min_frozen", min_bcd, 8'h59);

      // mode + inc together: mode wins
      cyc(1'b0, 1'b1, 1'b1);
      chk("modeinc.mode", 8'(mode), 8'd3);
      chk("modeinc.min", min_bcd, 8'h59);
      chk("modeinc.divclr", 8'(div_clr), 8'd0);

      incs(53);
      chk("sets.sec58", sec_bcd, 8'h58);
      chk("sets.min_nocarry", min_bcd, 8'h59);

      cyc(1'b0, 1'b1, 1'b0);
      chk("exit.mode", 8'(mode), 8'd0);
      chk("exit.divclr", 8'(div_clr), 8'd1);
      chk("exit.blank", 8'(blank), 8'h0);
      ticks(1);
      chk("exit.divclr_off", 8'(div_clr), 8'd0);
      chk("t1.sec", sec_bcd, 8'h59);
      chk("t1.min", min_bcd, 8'h59);
      chk("t1.hour", hour_bcd, 8'h23);
      ticks(1);
      chk("t2.sec", sec_bcd, 8'h00);
      chk("t2.min", min_bcd, 8'h00);
      chk("t2.hour", hour_bcd, 8'h00);

      // tick + mode together in RUN at sec 09
      ticks(9);
      chk("pre.sec", sec_bcd, 8'h09);
      cyc(1'b1, 1'b1, 1'b0);
      chk("tickmode.sec", sec_bcd, 8'h10);
      chk("tickmode.mode", 8'(mode), 8'd1);
      chk("tickmode.blank", 8'(blank), 8'h0);

      // back to RUN (second div_clr), then a full 4-step lap
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("lap0.mode", 8'(mode), 8'd0);
      chk("lap0.divclr", 8'(div_clr), 8'd1);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0);
         chk($sformatf("lap%0d.mode", k), 8'(mode), 8'(k % 4));
         chk($sformatf("lap%0d.divclr", k), 8'(div_clr), (k == 4) ? 8'd1 : 8'd0);
      end
      cyc(1'b0, 1'b0, 1'b0);
      chk("divclr.count", 8'(dc_cnt), 8'd3);

      // asynchronous reset mid-set
      cyc(1'b0, 1'b1, 1'b0);
      incs(3);
      ticks(1);
      chk("midset.hour", hour_bcd, 8'h03);
      chk("midset.blank", 8'(blank), 8'h4);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("async_rst");
      #20;
      rst_n = 1'b1;
      @(posedge clk_27MHz); #1;
      chk_reset("rel_rst");
      chk("divclr.count_end", 8'(dc_cnt), 8'd3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping and set-mode controller for the digital clock. Consumes the single-cycle 1 Hz enable from the 1 s divider, sequences the hours/minutes/seconds BCD counters, runs the user-set state machine driven by debounced key pulses, and restarts the divider when leaving set mode. Outputs feed the display scanning block directly.

## Interface
- `RST_HOUR`, 8'h12: BCD hour loaded on reset.
- `RST_MIN`, 8'h00: BCD minute loaded on reset.
- `RST_SEC`, 8'h00: BCD second loaded on reset.
- `clk_27MHz`  in  1  system clock, 27 MHz; sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second, from the 1 s divider.
- `key_mode`  in  1  one-cycle debounced pulse: advance mode.
- `key_inc`  in  1  one-cycle debounced pulse: increment selected field.
- `hour_bcd`  out  8  hours, BCD 00–23.
- `min_bcd`  out  8  minutes, BCD 00–59.
- `sec_bcd`  out  8  seconds, BCD 00–59.
- `mode`  out  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- `blank`  out  3  per-field blank mask {hour,min,sec} for the display blink.
- `div_clr`  out  1  one-cycle pulse restarting the 1 s divider count.

## Operation
- States: RUN → SET_H → SET_M → SET_S → RUN, one step per `key_mode` pulse.
- RUN: on `tick_1hz`, sec +1; sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00. 23:59:59 + tick → 00:00:00.
- SET states: time does not advance on ticks. `key_inc` increments the selected field only, wrapping with no carry (hour 23→00, min 59→00, sec 59→00).
- Leaving SET_S for RUN: `div_clr` high for exactly one cycle, so the first second after setting is full length.
- Blink phase: 1-bit register toggled on every `tick_1hz` in all states; cleared on entering any SET state and on reset.
- `blank`: in SET states, the selected field's bit = blink phase, others 0; in RUN always 3'b000.
- Simultaneous events:
  - `key_mode` and `key_inc` in the same cycle: mode advances, inc ignored.
  - RUN with `tick_1hz` and `key_mode` together: the tick is applied, then the state becomes SET_H.
  - SET state with `tick_1hz` and `key_inc` together: the increment is applied; the tick only toggles the blink phase.
- BCD arithmetic: low digit 9→0 carries to high digit. Only legal BCD values are ever produced. Reset parameters must be legal values.

## Timing
- All outputs are registered. Counter updates are visible the cycle after the causing pulse.
- `div_clr` is asserted the cycle after the `key_mode` pulse that exits SET_S.
- `mode` updates the cycle after `key_mode`.
- Reset values: `hour_bcd`=`RST_HOUR`, `min_bcd`=`RST_MIN`, `sec_bcd`=`RST_SEC`, `mode`=0 (RUN), `blank`=0, `div_clr`=0, blink phase=0.
- Reset asserted mid-operation, including mid-set: all of the above are restored immediately (asynchronous). No pulse is emitted on release.
- Input pulses are assumed one cycle wide. A level held high is treated as one pulse per cycle; upstream debounce guarantees this does not happen.

## Structure
- Shared package `clock_pkg`:
  - mode encoding constants `MODE_RUN`/`MODE_SET_H`/`MODE_SET_M`/`MODE_SET_S`;
  - field limits `HOUR_MAX`=8'h23, `MIN_MAX`=`SEC_MAX`=8'h59.
- One sub-module, `bcd_wrap_counter`:
  - parameter MAX (BCD);
  - inputs `inc`, `load`, `load_val`;
  - outputs 8-bit BCD value and `wrap` (combinational, high when `inc` and value==MAX).
- Instantiated three times. RUN chains the `wrap` signals; SET states drive `inc` from `key_inc` with the chain gated.

## Test plan
- Reset with defaults → 12:00:00, mode 0, blank 000, div_clr 0. Apply 5 ticks → sec_bcd 8'h05.
- Load 23:59:58 via SET path, return to RUN, apply 2 ticks → 23:59:59 then 00:00:00.
- From RUN, key_mode ×1 then key_inc ×13 → hour 12→01 (wraps past 23). Min and sec unchanged; ticks in SET_H do not advance sec.
- key_mode ×4 from RUN → mode 1,2,3,0. div_clr is a single 1-cycle pulse exactly on the 3→0 transition, never otherwise.
- Same-cycle key_mode+key_inc in SET_M → mode 3, min unchanged. Same-cycle tick+key_mode in RUN at sec 8'h09 → sec 8'h10, mode 1.
- In SET_M, apply ticks → blank toggles 010/000 per tick. Assert rst_n low mid-sequence → all outputs at reset values in the same cycle.
